udivider: RTL and testbench

Sequential unsigned integer divider, the inverse companion of the unsigned multiplier in the arithmetic datapath. Computes quotient and remainder of two WIDTH-bit unsigned operands with a radix-2 restoring algorithm, one quotient bit per clock. A start/busy/done handshake lets the control unit issue a divide and stall until the result is valid. Division by zero is detected and returns a defined result in one iteration cycle.

---
 rtl/udivider_pkg.sv | 6 +
 rtl/udivider_step.sv | 19 +
 rtl/udivider.sv | 81 ++++++++
 tb/tb_udivider.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/udivider_pkg.sv
// udivider_pkg: shared arithmetic types and constants for the divider datapath.
package udivider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_WIDTH = 32;
  localparam logic [63:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/udivider_step.sv
// udivider_step: one radix-2 restoring iteration on the {rem, quo} pair.
module udivider_step
  import udivider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH+1:0] sh, trial;
  // one spare bit on top so the borrow of the trial subtraction is explicit
  assign sh    = {rem_i, quo_i[WIDTH-1]};
  assign trial = sh - {2'b0, divisor_i};
  assign rem_o = trial[WIDTH+1] ? sh[WIDTH:0] : trial[WIDTH:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH+1]};
endmodule

// File: rtl/udivider.sv
// udivider: sequential unsigned divider, one restoring quotient bit per clock,
// with start/busy/done handshake and divide-by-zero detection.
module udivider
  import udivider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e           state_q;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d, div_q, quotient_q, remainder_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  udivider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .divisor_i(div_q), .rem_o(rem_d), .quo_o(quo_d)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (state_q == RUN) begin
      if (div_q == '0) begin
        // quo_q still holds the untouched dividend here
        quotient_q  <= DIV0_QUOTIENT[WIDTH-1:0];
        remainder_q <= quo_q;
        dbz_q       <= 1'b1;
        done_q      <= 1'b1;
        busy_q      <= 1'b0;
        state_q     <= DONE;
      end else begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quotient_q  <= quo_d;
          remainder_q <= rem_d[WIDTH-1:0];
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= DONE;
        end
      end
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quo_q   <= in1;
        div_q   <= in2;
        rem_q   <= '0;
        cnt_q   <= CW'(WIDTH);
        dbz_q   <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= RUN;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_udivider.sv
// tb_udivider: scoreboard bench for udivider; stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_udivider;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  udivider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         z;
    int           t;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(mon_e.q));
        chk("remainder", 64'(remainder), 64'(mon_e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.z));
        chk("done_cycle", 64'(cyc), 64'(mon_e.t));
        chk("busy_at_done", 64'(busy), 64'(0));
        if (mon_e.b != '0) begin
          chk("inv_product", 64'(quotient) * 64'(mon_e.b) + 64'(remainder), 64'(mon_e.a));
          chk("inv_rem_lt_div", 64'(remainder < mon_e.b), 64'(1));
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles expected busy=0", k);
    end
  endtask

  // entered and left on a falling edge; start is sampled on the next rising edge
  task automatic issue(input logic [W-1:0] a, b, q, r, input logic z);
    wait_idle();
    start = 1'b1;
    in1 = a;
    in2 = b;
    sb.push_back('{a: a, b: b, q: q, r: r, z: z, t: cyc + 1 + ((b == '0) ? 1 : W)});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int mode;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_quotient", 64'(quotient), 64'(0));
    chk("rst_remainder", 64'(remainder), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    issue(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    issue(32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
    issue(32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1);
    issue(32'd10, 32'd3, 32'd3, 32'd1, 1'b0);

    // a start raised at iteration 5 must be ignored
    issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    in1 = 32'd7;
    in2 = 32'd2;
    @(negedge clk);
    start = 1'b0;
    issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);

    // asynchronous reset mid-RUN at iteration 12; this op is never completed
    wait_idle();
    start = 1'b1;
    in1 = 32'd123456;
    in2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_quotient", 64'(quotient), 64'(0));
    chk("arst_remainder", 64'(remainder), 64'(0));
    chk("arst_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      ra = $urandom;
      mode = $urandom_range(0, 9);
      rb = (mode == 0) ? '0 : (mode < 5) ? W'($urandom_range(1, 255)) : $urandom;
      if (rb == '0) issue(ra, rb, '1, ra, 1'b1);
      else issue(ra, rb, ra / rb, ra % rb, 1'b0);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
